// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types and constants for the mux function sequencer.
//   state_t      FSM states IDLE/DRIVE/SAMPLE/DONE
//   CODE_*       2-bit per-input data codes (0, 1, D, ~D)
//   NMINTERM     number of ABCD minterms swept
package mux_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_D    = 2'b10;
  localparam logic [1:0] CODE_ND   = 2'b11;

  localparam int NMINTERM = 16;
endpackage

// File: rtl/mux_func_sequencer_if.sv
// mux_seq_if: host + external-mux signal bundle for mux_func_sequencer.
//   host side : start, abort, cfg_code -> ; busy, done, truth_table <-
//   mux side  : mux_sel, mux_i -> mux81b ; mux_y <- mux81b
//   MUXSEQ_SELFCHECK_EN adds mismatch / err_minterm.
//   slave  = the sequencer, master = host/bench.
interface mux_seq_if;
  logic        start;
  logic        abort;
  logic [15:0] cfg_code;
  logic [2:0]  mux_sel;
  logic [7:0]  mux_i;
  logic        mux_y;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
`ifdef MUXSEQ_SELFCHECK_EN
  logic        mismatch;
  logic [3:0]  err_minterm;

  modport slave  (input  start, abort, cfg_code, mux_y,
                  output mux_sel, mux_i, busy, done, truth_table, mismatch, err_minterm);
  modport master (output start, abort, cfg_code, mux_y,
                  input  mux_sel, mux_i, busy, done, truth_table, mismatch, err_minterm);
`else
  modport slave  (input  start, abort, cfg_code, mux_y,
                  output mux_sel, mux_i, busy, done, truth_table);
  modport master (output start, abort, cfg_code, mux_y,
                  input  mux_sel, mux_i, busy, done, truth_table);
`endif
endinterface

// File: rtl/mux_input_decoder.sv
// mux_input_decoder: combinational decode of 8 x 2-bit input codes into the
// mux data lines for a given D.
//   cfg   [15:0] bits [2k+1:2k] code for I[k]
//   d            current D variable
//   i_out [7:0]  mux data inputs I[7:0]
module mux_input_decoder
  import mux_seq_pkg::*;
(
  input  logic [15:0] cfg,
  input  logic        d,
  output logic [7:0]  i_out
);
  for (genvar k = 0; k < 8; k++) begin : g_lane
    always_comb begin
      i_out[k] = 1'b0;
      case (cfg[2*k +: 2])
        CODE_ZERO: i_out[k] = 1'b0;
        CODE_ONE:  i_out[k] = 1'b1;
        CODE_D:    i_out[k] = d;
        CODE_ND:   i_out[k] = ~d;
        default:   i_out[k] = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/mux_func_sequencer.sv
// mux_func_sequencer: sweeps ABCD over 16 minterms on an external 8:1 mux
// configured as a 4-input function generator and captures the truth table.
//   clk, rst_n  clock, async active-low reset
//   bus         mux_seq_if.slave (host handshake + mux drive/sense)
//   DWELL       cycles select/data are held before mux_y is sampled (1..15)
//   CNT_W       dwell counter width
// Optional: MUXSEQ_SELFCHECK_EN compares mux_y against the expected value
// from the latched cfg and flags the first failing minterm.
module mux_func_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int CNT_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_seq_if.slave  bus
);
  state_t                state, nxt_state;
  logic [3:0]            minterm;
  logic [CNT_W-1:0]      cnt;
  logic [15:0]           cfg_q;
  logic [NMINTERM-1:0]   tt;
  logic [7:0]            dec_i;
  logic                  accept;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  // abort beats start in IDLE
  assign accept = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (accept) nxt_state = DRIVE;
      DRIVE:   if (bus.abort)              nxt_state = IDLE;
               else if (cnt == DWELL_LAST) nxt_state = SAMPLE;
      SAMPLE:  if (bus.abort)              nxt_state = IDLE;
               else if (minterm == 4'd15)  nxt_state = DONE;
               else                        nxt_state = DRIVE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      minterm <= '0;
      cnt     <= '0;
      cfg_q   <= '0;
      tt      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cfg_q   <= bus.cfg_code;
          tt      <= '0;
          minterm <= '0;
          cnt     <= '0;
        end
        DRIVE:  cnt <= cnt + 1'b1;
        SAMPLE: begin
          // sample lands even on an aborting cycle; the mux was settled
          tt[minterm] <= bus.mux_y;
          cnt         <= '0;
          if (minterm != 4'd15) minterm <= minterm + 1'b1;
        end
        default: ;
      endcase
    end

  mux_input_decoder u_dec (.cfg(cfg_q), .d(minterm[0]), .i_out(dec_i));

  // mux lines parked at 0 outside the sweep so reset/idle look identical
  assign bus.busy        = (state == DRIVE) || (state == SAMPLE);
  assign bus.done        = (state == DONE);
  assign bus.mux_sel     = bus.busy ? minterm[3:1] : 3'd0;
  assign bus.mux_i       = bus.busy ? dec_i : 8'd0;
  assign bus.truth_table = tt;

`ifdef MUXSEQ_SELFCHECK_EN
  logic       mism_q;
  logic [3:0] err_q;
  logic       exp_y;

  assign exp_y = dec_i[minterm[3:1]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mism_q <= 1'b0;
      err_q  <= '0;
    end else if (accept) begin
      mism_q <= 1'b0;
      err_q  <= '0;
    end else if (state == SAMPLE && bus.mux_y != exp_y && !mism_q) begin
      mism_q <= 1'b1;
      err_q  <= minterm;
    end

  assign bus.mismatch    = mism_q;
  assign bus.err_minterm = err_q;
`endif
endmodule

// File: tb/tb_mux_func_sequencer.sv
// tb_mux_func_sequencer: directed bench with a behavioural mux81b and a
// scoreboard of expected truth tables (pushed at start, popped at done).
module tb_mux_func_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   inj = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  mux_seq_if bus();

  mux_func_sequencer #(.DWELL(1), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // mux81b; optional fault injection at minterm 7 (sel=3, D=1 seen on I2 for cfg C8AF)
  assign bus.mux_y = bus.mux_i[bus.mux_sel] ^ (inj && bus.mux_sel == 3'd3 && bus.mux_i[2]);

  function automatic logic [15:0] model(input logic [15:0] cfg);
    logic [15:0] r;
    logic [1:0]  c;
    logic        d;
    r = '0;
    for (int m = 0; m < 16; m++) begin
      c = cfg[2*(m>>1) +: 2];
      d = m[0];
      case (c)
        2'b00: r[m] = 1'b0;
        2'b01: r[m] = 1'b1;
        2'b10: r[m] = d;
        default: r[m] = ~d;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n, output int busy_n, output int done_n);
    busy_n = 0; done_n = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
    end
  endtask

  task automatic do_sweep(input logic [15:0] cfg, input logic [15:0] exp,
                          input bit chk_lat, input bit disturb);
    int cyc, busy_n, done_n;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    bus.cfg_code = cfg; bus.start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1;
      if (disturb && cyc == 10) begin bus.start = 1'b1; bus.cfg_code = ~cfg; end
      if (disturb && cyc == 11) bus.start = 1'b0;
      if (disturb && seen) bus.start = 1'b1;  // sampled while in DONE
    end
    check("done_seen", 32'(seen), 32'd1);
    if (chk_lat) begin
      check("done_latency", cyc, 33);
      check("busy_cycles", busy_n, 32);
    end
    e = sb.pop_front();
    check("truth_table", 32'(bus.truth_table), 32'(e));
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse_width", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    if (disturb) begin
      idle_cycles(40, busy_n, done_n);
      check("no_requeue_busy", busy_n, 0);
      check("no_extra_done", done_n, 0);
    end
  endtask

  initial begin
    int busy_n, done_n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_code = '0;

    // reset state
    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_tt", 32'(bus.truth_table), 0);
    check("rst_sel", 32'(bus.mux_sel), 0);
    check("rst_i", 32'(bus.mux_i), 0);
    @(negedge clk); rst_n = 1'b1;

    // reference sweep
    check("model_c8af", 32'(model(16'hC8AF)), 32'h48A5);
    do_sweep(16'hC8AF, 16'h48A5, 1'b1, 1'b0);

    // constant configurations
    do_sweep(16'h5555, 16'hFFFF, 1'b1, 1'b0);
    do_sweep(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_sweep(16'hAAAA, 16'hAAAA, 1'b1, 1'b0);
    do_sweep(16'h1B36, model(16'h1B36), 1'b1, 1'b0);

    // abort after minterm 5 is sampled
    @(negedge clk);
    bus.cfg_code = 16'hC8AF; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    idle_cycles(40, busy_n, done_n);
    check("abort_no_done", done_n, 0);
    check("abort_partial_tt", 32'(bus.truth_table), 32'(16'h48A5 & 16'h003F));
    do_sweep(16'h5555, 16'hFFFF, 1'b1, 1'b0);

    // abort + start together in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_wins_busy", 32'(bus.busy), 0);

    // mid-sweep start/cfg changes ignored, start during DONE ignored
    do_sweep(16'hC8AF, 16'h48A5, 1'b1, 1'b1);

`ifdef MUXSEQ_SELFCHECK_EN
    inj = 1'b1;
    do_sweep(16'hC8AF, 16'h48A5 ^ 16'h0080, 1'b1, 1'b0);
    inj = 1'b0;
    check("sc_mismatch", 32'(bus.mismatch), 1);
    check("sc_err_minterm", 32'(bus.err_minterm), 7);
    idle_cycles(5, busy_n, done_n);
    check("sc_sticky", 32'(bus.mismatch), 1);
    do_sweep(16'hC8AF, 16'h48A5, 1'b0, 1'b0);
    check("sc_cleared", 32'(bus.mismatch), 0);
    check("sc_err_cleared", 32'(bus.err_minterm), 0);
`endif

    // asynchronous reset mid-sweep
    @(negedge clk);
    bus.cfg_code = 16'hC8AF; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_tt", 32'(bus.truth_table), 0);
    check("mid_rst_sel", 32'(bus.mux_sel), 0);
    check("mid_rst_i", 32'(bus.mux_i), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    @(negedge clk); rst_n = 1'b1;
    do_sweep(16'hAAAA, 16'hAAAA, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_func_sequencer.md
Name: mux_func_sequencer

Overview:
Controller for the 8:1 multiplexer used as a 4-variable function generator (select = A,B,C; data inputs driven from 0, 1, D or ~D).
- Loads a per-input configuration code.
- Sweeps ABCD through all 16 minterms, driving the mux select and data lines and waiting a programmable settle time per minterm.
- Samples the mux output and assembles a 16-bit truth table.
- Sits between a test/host interface and an external mux81b instance.

Parameters:
DWELL, 1, cycles the select/data lines are held before sampling mux_y; legal range 1..15
CNT_W, 4, width of the dwell counter; must hold DWELL

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  terminate a sweep in progress
cfg_code  input  16  8 x 2-bit input codes; bits [2k+1:2k] select I[k]: 00=0, 01=1, 10=D, 11=~D
mux_sel  output  3  drive to mux select, {A,B,C}, A=MSB
mux_i  output  8  drive to mux data inputs I[7:0]
mux_y  input  1  mux output
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at sweep completion
truth_table  output  16  bit m = sampled Y for minterm m = {A,B,C,D}

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; minterm = 0; dwell counter = 0.
  - cfg register = 0; truth_table = 0; busy = 0; done = 0.
  - mux_sel = 0; mux_i = 0.
- Outputs are registered or derived only from registers. mux_i is decoded from the latched cfg and the current D = minterm[0].
- IDLE:
  - start=1 → latch cfg_code, clear truth_table, set minterm = 0, go to DRIVE.
  - start=0 → hold; truth_table keeps its last result.
- DRIVE:
  - mux_sel = minterm[3:1]; mux_i = decode(cfg, minterm[0]).
  - The dwell counter counts DWELL cycles, then the state moves to SAMPLE.
- SAMPLE (one cycle):
  - truth_table[minterm] <= mux_y.
  - If minterm = 15, go to DONE. Otherwise minterm++, clear the dwell counter, return to DRIVE.
- DONE (one cycle): done = 1, then IDLE. The minterm counter does not wrap past 15.
- busy = 1 in DRIVE and SAMPLE only.
- Latency: start sampled at edge k → done high during cycle k+1+16*(DWELL+1).
- start while busy or in DONE: ignored, no queuing.
- cfg_code changes during a sweep: no effect; the latched copy is used.
- abort in DRIVE/SAMPLE: next state IDLE, no done pulse, truth_table holds partial results.
- abort and start together in IDLE: abort wins; stay IDLE.
- Reset mid-sweep: all state is cleared immediately.

Optional Feature:
MUXSEQ_SELFCHECK_EN:
- Defined:
  - The block computes the expected Y from the latched cfg in SAMPLE and compares it with mux_y.
  - Adds output mismatch (1 bit, sticky until next accepted start, reset 0).
  - Adds output err_minterm (4 bits): first failing minterm, reset 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mux_seq_pkg:
  - State enum: IDLE, DRIVE, SAMPLE, DONE.
  - Code constants: CODE_ZERO=2'b00, CODE_ONE=2'b01, CODE_D=2'b10, CODE_ND=2'b11.
  - Constant NMINTERM=16.
- Sub-module mux_input_decoder: combinational; cfg[15:0] + D → I[7:0]. Reused by the self-check path.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately; state IDLE.
- Full sweep, DWELL=1, cfg_code=16'hC8AF (I0=~D, I1=~D, I2=D, I3=D, I4=0, I5=D, I6=0, I7=~D), bench mux81b connected → done exactly 33 cycles after the start edge; truth_table=16'h48A5; busy high for 32 cycles.
- Constant configurations: cfg=16'h5555 → truth_table=16'hFFFF; cfg=16'h0000 → 16'h0000; cfg=16'hAAAA → 16'hAAAA.
- Abort after minterm 5 sampled → IDLE with no done pulse; truth_table bits [5:0] valid, bits [15:6] = 0; a new start then completes normally.
- Start pulses and cfg_code changes mid-sweep → ignored; the result matches the original cfg; a single done pulse.
- With MUXSEQ_SELFCHECK_EN: bench forces mux_y inverted at minterm 7 → mismatch=1, err_minterm=7, sticky until next start.
